// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: address/pixel widths, loader state encoding
// and the RGB pixel bundle carried from the host stream to the strip RAMs.
package ws2812_pkg;
  localparam int LED_ADDR_WIDTH = 9;
  localparam int PIXEL_WIDTH    = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;
endpackage

// File: rtl/pixel_position_counter.sv
// Nested led/strip position counter. inc advances one pixel, clr returns to
// the origin, clr+inc together lands on the pixel right after the origin.
module pixel_position_counter
  import ws2812_pkg::*;
#(
  parameter int STRIP_COUNT = 8,
  parameter int LED_COUNT   = 240,
  localparam int SW         = (STRIP_COUNT > 1) ? $clog2(STRIP_COUNT) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      inc_i,
  input  logic                      clr_i,
  output logic [LED_ADDR_WIDTH-1:0] led_cnt_o,
  output logic [SW-1:0]             strip_cnt_o,
  output logic                      last_o
);
  localparam logic [LED_ADDR_WIDTH-1:0] LED_LAST   = LED_ADDR_WIDTH'(LED_COUNT - 1);
  localparam logic [SW-1:0]             STRIP_LAST = SW'(STRIP_COUNT - 1);
  // With a single LED per strip, the pixel after the origin is on strip 1.
  localparam logic [LED_ADDR_WIDTH-1:0] FIRST_LED   = (LED_COUNT == 1) ? '0 : LED_ADDR_WIDTH'(1);
  localparam logic [SW-1:0]             FIRST_STRIP = (LED_COUNT == 1 && STRIP_COUNT > 1) ? SW'(1) : '0;

  logic led_wrap;
  assign led_wrap = (led_cnt_o == LED_LAST);
  assign last_o   = led_wrap && (strip_cnt_o == STRIP_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      led_cnt_o   <= '0;
      strip_cnt_o <= '0;
    end else if (clr_i) begin
      led_cnt_o   <= inc_i ? FIRST_LED : '0;
      strip_cnt_o <= inc_i ? FIRST_STRIP : '0;
    end else if (inc_i) begin
      if (led_wrap) begin
        led_cnt_o   <= '0;
        strip_cnt_o <= (strip_cnt_o == STRIP_LAST) ? '0 : strip_cnt_o + SW'(1);
      end else begin
        led_cnt_o   <= led_cnt_o + LED_ADDR_WIDTH'(1);
      end
    end
  end
endmodule

// File: rtl/strip_frame_loader.sv
// Sequences a sof-framed valid/ready pixel stream into per-strip pixel RAMs,
// strip 0 first, with registered one-hot strobe, shared address and RGB.
module strip_frame_loader
  import ws2812_pkg::*;
#(
  parameter int STRIP_COUNT = 8,
  parameter int LED_COUNT   = 240
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      enable_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  input  logic                      s_sof_i,
  input  logic [7:0]                s_r_i,
  input  logic [7:0]                s_g_i,
  input  logic [7:0]                s_b_i,
  output logic [STRIP_COUNT-1:0]    we_o,
  output logic [LED_ADDR_WIDTH-1:0] addr_o,
  output logic [7:0]                r_o,
  output logic [7:0]                g_o,
  output logic [7:0]                b_o,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      sync_err_o
);
  localparam int SW           = (STRIP_COUNT > 1) ? $clog2(STRIP_COUNT) : 1;
  localparam bit SINGLE_PIXEL = (STRIP_COUNT == 1) && (LED_COUNT == 1);

  loader_state_t             state, state_nxt;
  logic [LED_ADDR_WIDTH-1:0] led_cnt;
  logic [SW-1:0]             strip_cnt;
  logic                      cnt_last, cnt_inc, cnt_clr;
  logic                      accept, wr, wr_origin, err;
  logic [SW-1:0]             wr_strip;
  logic [PIXEL_WIDTH-1:0]    rgb_q;
  pixel_t                    pix;

  assign s_ready_o = enable_i && (state != DONE);
  assign accept    = s_valid_i && s_ready_o;
  assign busy_o    = (state == LOAD);
  assign wr_strip  = wr_origin ? '0 : strip_cnt;
  assign pix       = rgb_q;
  assign r_o       = pix.r;
  assign g_o       = pix.g;
  assign b_o       = pix.b;

  pixel_position_counter #(
    .STRIP_COUNT (STRIP_COUNT),
    .LED_COUNT   (LED_COUNT)
  ) u_pos (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .inc_i       (cnt_inc),
    .clr_i       (cnt_clr),
    .led_cnt_o   (led_cnt),
    .strip_cnt_o (strip_cnt),
    .last_o      (cnt_last)
  );

  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    wr_origin = 1'b0;
    err       = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (s_sof_i) begin
          wr        = 1'b1;
          wr_origin = 1'b1;
          cnt_clr   = 1'b1;
          cnt_inc   = 1'b1;
          state_nxt = SINGLE_PIXEL ? DONE : LOAD;
        end else begin
          err = 1'b1;
        end
      end
      LOAD: if (accept) begin
        wr      = 1'b1;
        cnt_inc = 1'b1;
        if (s_sof_i) begin
          // Short frame: restart from the origin with this beat.
          err       = 1'b1;
          wr_origin = 1'b1;
          cnt_clr   = 1'b1;
        end else if (cnt_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      we_o         <= '0;
      addr_o       <= '0;
      rgb_q        <= '0;
      frame_done_o <= 1'b0;
      sync_err_o   <= 1'b0;
    end else begin
      state        <= state_nxt;
      we_o         <= wr ? (STRIP_COUNT'(1) << wr_strip) : '0;
      frame_done_o <= (state_nxt == DONE) && (state != DONE);
      sync_err_o   <= err;
      if (wr) begin
        addr_o <= wr_origin ? '0 : led_cnt;
        rgb_q  <= {s_r_i, s_g_i, s_b_i};
      end
    end
  end
endmodule

// File: tb/tb_strip_frame_loader.sv
// Directed bench: small 2x3 loader for framing/gating/reset cases and a
// 1x512 loader for the full address range.
module tb_strip_frame_loader;
  logic       clk = 1'b0;
  logic       rst_n;
  int         n_tests = 0;
  int         n_fail  = 0;

  // 2 strips x 3 LEDs
  logic       en, vld, sof, rdy, busy, done, serr;
  logic [7:0] r, g, b, ro, go, bo;
  logic [1:0] we;
  logic [8:0] addr;

  // 1 strip x 512 LEDs
  logic       en1, vld1, sof1, rdy1, busy1, done1, serr1;
  logic [7:0] ro1, go1, bo1;
  logic [0:0] we1;
  logic [8:0] addr1;

  always #5 clk = ~clk;

  strip_frame_loader #(.STRIP_COUNT(2), .LED_COUNT(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en), .s_valid_i(vld), .s_ready_o(rdy),
    .s_sof_i(sof), .s_r_i(r), .s_g_i(g), .s_b_i(b), .we_o(we), .addr_o(addr),
    .r_o(ro), .g_o(go), .b_o(bo), .busy_o(busy), .frame_done_o(done), .sync_err_o(serr)
  );

  strip_frame_loader #(.STRIP_COUNT(1), .LED_COUNT(512)) dut_max (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en1), .s_valid_i(vld1), .s_ready_o(rdy1),
    .s_sof_i(sof1), .s_r_i(8'h11), .s_g_i(8'h22), .s_b_i(8'h33), .we_o(we1), .addr_o(addr1),
    .r_o(ro1), .g_o(go1), .b_o(bo1), .busy_o(busy1), .frame_done_o(done1), .sync_err_o(serr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Present a beat, clock it, and land #1 after the edge.
  task automatic beat(input logic s, input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    vld = 1'b1; sof = s; r = rr; g = gg; b = bb;
    @(posedge clk); #1;
  endtask

  task automatic chk_wr(input string tag, input logic [1:0] w, input logic [8:0] a,
                        input logic fd, input logic se);
    chk({tag, ".we"},   32'(we),   32'(w));
    chk({tag, ".addr"}, 32'(addr), 32'(a));
    chk({tag, ".done"}, 32'(done), 32'(fd));
    chk({tag, ".err"},  32'(serr), 32'(se));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; vld = 1'b0; sof = 1'b0; r = '0; g = '0; b = '0;
    en1 = 1'b0; vld1 = 1'b0; sof1 = 1'b0;
    #23 rst_n = 1'b1;
    #1;
    chk("rst.we", 32'(we), 0);
    chk("rst.addr", 32'(addr), 0);
    chk("rst.rgb", {8'h0, ro, go, bo}, 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.ready", 32'(rdy), 1);
    @(posedge clk); #1;

    // Clean frame: strip 0 then strip 1
    for (int i = 0; i < 6; i++) begin
      beat(i == 0, 8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i));
      chk_wr($sformatf("clean%0d", i), (i < 3) ? 2'b01 : 2'b10, 9'(i % 3), i == 5, 1'b0);
      chk($sformatf("clean%0d.r", i), 32'(ro), 32'(8'h10 + 8'(i)));
      chk($sformatf("clean%0d.ready", i), 32'(rdy), (i == 5) ? 0 : 1);
    end
    vld = 1'b0;
    chk("clean.busy_done", 32'(busy), 0);
    @(posedge clk); #1;
    chk_wr("clean.after", 2'b00, 9'd2, 1'b0, 1'b0);
    chk("clean.ready_back", 32'(rdy), 1);

    // Stray beats in IDLE
    beat(1'b0, 8'h01, 8'h02, 8'h03);
    chk("stray0.we", 32'(we), 0);
    chk("stray0.err", 32'(serr), 1);
    beat(1'b0, 8'h01, 8'h02, 8'h03);
    chk("stray1.we", 32'(we), 0);
    chk("stray1.err", 32'(serr), 1);
    chk("stray.busy", 32'(busy), 0);
    beat(1'b1, 8'h44, 8'h55, 8'h66);
    chk_wr("stray.sof", 2'b01, 9'd0, 1'b0, 1'b0);
    chk("stray.busy2", 32'(busy), 1);

    // Short frame: 4 beats total, then a new sof
    for (int i = 1; i < 4; i++) begin
      beat(1'b0, 8'h00, 8'h00, 8'h00);
      chk_wr($sformatf("short%0d", i), (i < 3) ? 2'b01 : 2'b10, 9'(i % 3), 1'b0, 1'b0);
    end
    beat(1'b1, 8'hFF, 8'h00, 8'h80);
    chk_wr("short.restart", 2'b01, 9'd0, 1'b0, 1'b1);
    chk("short.rgb", {8'h0, ro, go, bo}, 32'h00FF0080);
    for (int i = 1; i < 6; i++) begin
      beat(1'b0, 8'h00, 8'h00, 8'h00);
      chk_wr($sformatf("short.fin%0d", i), (i < 3) ? 2'b01 : 2'b10, 9'(i % 3), i == 5, 1'b0);
    end
    vld = 1'b0;
    @(posedge clk); #1;

    // Enable gating mid-frame
    for (int i = 0; i < 3; i++) begin
      beat(i == 0, 8'h00, 8'h00, 8'h00);
      chk_wr($sformatf("gate%0d", i), 2'b01, 9'(i), 1'b0, 1'b0);
    end
    en = 1'b0; sof = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("gate.off%0d.ready", i), 32'(rdy), 0);
      @(posedge clk); #1;
      chk_wr($sformatf("gate.off%0d", i), 2'b00, 9'd2, 1'b0, 1'b0);
    end
    en = 1'b1;
    beat(1'b0, 8'h5A, 8'hA5, 8'h3C);
    chk_wr("gate.resume", 2'b10, 9'd0, 1'b0, 1'b0);

    // Asynchronous reset between edges while outputs are live
    #2 rst_n = 1'b0;
    #1;
    chk("arst.we", 32'(we), 0);
    chk("arst.addr", 32'(addr), 0);
    chk("arst.rgb", {8'h0, ro, go, bo}, 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.err", 32'(serr), 0);
    vld = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    beat(1'b1, 8'h77, 8'h00, 8'h00);
    chk_wr("arst.sof", 2'b01, 9'd0, 1'b0, 1'b0);
    chk("arst.r", 32'(ro), 32'h77);
    vld = 1'b0;

    // Max size: 1 strip x 512
    en1 = 1'b1; vld1 = 1'b1;
    for (int i = 0; i < 512; i++) begin
      sof1 = (i == 0);
      @(posedge clk); #1;
      chk($sformatf("max%0d.addr", i), 32'(addr1), 32'(i));
      if (i == 0 || i == 510 || i == 511) begin
        chk($sformatf("max%0d.we", i), 32'(we1), 1);
        chk($sformatf("max%0d.done", i), 32'(done1), (i == 511) ? 1 : 0);
      end
    end
    vld1 = 1'b0;
    chk("max.ready_done", 32'(rdy1), 0);
    @(posedge clk); #1;
    chk("max.after.we", 32'(we1), 0);
    chk("max.after.done", 32'(done1), 0);
    chk("max.after.addr", 32'(addr1), 511);
    chk("max.err", 32'(serr1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
